// File: rtl/warp_sequencer_pkg.sv
// warp_sequencer_pkg
// Shared widths, opcodes and FSM state encoding for the warp fetch/issue
// sequencer and its lane-completion tracker.
package warp_sequencer_pkg;

    localparam int INSTMEM_DATA_WIDTH = 32;
    localparam int INSTMEM_ADDR_WIDTH = 16;

    // Opcode lives in the top nibble of the instruction word.
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'hD;
    localparam logic [OPCODE_W-1:0] OP_BRZ  = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_UPDATE = 3'd5,
        ST_HALT   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/lane_done_tracker.sv
// lane_done_tracker
// Sticky per-lane completion mask. Pulses on core_done are accumulated only
// while enable is high; all_done already includes the current cycle's pulses
// so the sequencer can leave WAIT in the same cycle the last lane finishes.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   enable        accumulate core_done this cycle (sequencer in WAIT)
//   clear         empty the mask at the next edge
//   core_done     per-lane completion pulses
//   all_done      every lane has reported (mask | this cycle's pulses)
module lane_done_tracker #(
    parameter int NUM_CORES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 all_done
);

    logic [NUM_CORES-1:0] r_mask;
    logic [NUM_CORES-1:0] w_merged;

    assign w_merged = r_mask | (enable ? core_done : '0);
    assign all_done = enable & (&w_merged);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (clear) begin
            r_mask <= '0;
        end else if (enable) begin
            r_mask <= w_merged;
        end
    end

endmodule

// File: rtl/warp_sequencer.sv
// warp_sequencer
// Fetch/issue controller for one instruction stream shared by NUM_CORES
// SIMD lanes. Drives the PC controls, fetches a word, broadcasts it, waits
// for every lane, then increments, branches or halts.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// CLEAR  | pc_reset pulse, PC returns to 0
// FETCH  | imem_req high until imem_ack, word latched into instr
// ISSUE  | issue_valid high until issue_ready
// WAIT   | collecting core_done until every lane has finished
// UPDATE | incPC / loadFromI pulse (none for HALT)
// HALT   | halted high, start relaunches from address 0
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   start                    launch (IDLE/HALT only)
//   imem_req/ack/data        instruction memory handshake
//   pc_reset, incPC,         PC controls (mutually exclusive pulses)
//   loadFromI, I
//   issue_valid/ready, instr broadcast to the lanes
//   core_done                per-lane completion pulses
//   branch_cond              lane-0 condition for BRZ
//   busy, halted             status
module warp_sequencer
    import warp_sequencer_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int INSTR_W   = INSTMEM_DATA_WIDTH,
    parameter int ADDR_W    = INSTMEM_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic                 pc_reset,
    output logic                 incPC,
    output logic                 loadFromI,
    output logic [ADDR_W-1:0]    I,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [INSTR_W-1:0]   instr,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic                 branch_cond,
    output logic                 busy,
    output logic                 halted
);

    seq_state_t            r_state;
    logic [INSTR_W-1:0]    r_instr;
    logic                  r_imem_req;
    logic                  r_pc_reset;
    logic                  r_incpc;
    logic                  r_load;
    logic [ADDR_W-1:0]     r_i;
    logic                  r_issue_valid;
    logic                  r_busy;
    logic                  r_halted;

    logic                  w_in_wait;
    logic                  w_all_done;
    logic [OPCODE_W-1:0]   w_opcode;
    logic                  w_take_branch;

    assign w_in_wait     = (r_state == ST_WAIT);
    assign w_opcode      = r_instr[INSTR_W-1 -: OPCODE_W];
    assign w_take_branch = (w_opcode == OP_JMP) ||
                           ((w_opcode == OP_BRZ) && branch_cond);

    lane_done_tracker #(
        .NUM_CORES (NUM_CORES)
    ) u_done_tracker (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (w_in_wait),
        .clear     (w_all_done),
        .core_done (core_done),
        .all_done  (w_all_done)
    );

    // Outputs are registered alongside the state: each transition loads the
    // output values of the state being entered, so the PC pulse decided at
    // the WAIT->UPDATE edge is visible for exactly the UPDATE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_instr       <= '0;
            r_imem_req    <= 1'b0;
            r_pc_reset    <= 1'b0;
            r_incpc       <= 1'b0;
            r_load        <= 1'b0;
            r_i           <= '0;
            r_issue_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_pc_reset <= 1'b0;
            r_incpc    <= 1'b0;
            r_load     <= 1'b0;
            r_i        <= '0;
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_state    <= ST_CLEAR;
                        r_pc_reset <= 1'b1;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_state       <= ST_ISSUE;
                        r_instr       <= imem_data;
                        r_imem_req    <= 1'b0;
                        r_issue_valid <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (issue_ready) begin
                        r_state       <= ST_WAIT;
                        r_issue_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_all_done) begin
                        r_state <= ST_UPDATE;
                        if (w_take_branch) begin
                            r_load <= 1'b1;
                            r_i    <= r_instr[ADDR_W-1:0];
                        end else if (w_opcode != OP_HALT) begin
                            r_incpc <= 1'b1;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (w_opcode == OP_HALT) begin
                        r_state  <= ST_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign pc_reset    = r_pc_reset;
    assign incPC       = r_incpc;
    assign loadFromI   = r_load;
    assign I           = r_i;
    assign issue_valid = r_issue_valid;
    assign instr       = r_instr;
    assign busy        = r_busy;
    assign halted      = r_halted;

endmodule

// File: tb/tb_warp_sequencer.sv
// tb_warp_sequencer
// Directed scenarios plus a randomized program run. The bench owns a model
// PC driven by the sequencer's controls and compares it against the address
// the program semantics say should be fetched next.
module tb_warp_sequencer;

    localparam int NC = 4;
    localparam int IW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_data = '0;
    logic          issue_ready = 1'b0;
    logic [NC-1:0] core_done = '0;
    logic          branch_cond = 1'b0;

    logic          imem_req;
    logic          pc_reset;
    logic          incPC;
    logic          loadFromI;
    logic [AW-1:0] I;
    logic          issue_valid;
    logic [IW-1:0] instr;
    logic          busy;
    logic          halted;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [AW-1:0] pc_model;
    logic [AW-1:0] exp_addr;

    always #5 clk = ~clk;

    warp_sequencer #(
        .NUM_CORES (NC),
        .INSTR_W   (IW),
        .ADDR_W    (AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .pc_reset    (pc_reset),
        .incPC       (incPC),
        .loadFromI   (loadFromI),
        .I           (I),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .instr       (instr),
        .core_done   (core_done),
        .branch_cond (branch_cond),
        .busy        (busy),
        .halted      (halted)
    );

    // Program counter as the surrounding system would implement it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       pc_model <= '0;
        else if (pc_reset)  pc_model <= '0;
        else if (incPC)     pc_model <= pc_model + 16'd1;
        else if (loadFromI) pc_model <= I;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_no_pc_ctl(input string tag);
        chk({tag, "_pc_reset"}, pc_reset, 1'b0);
        chk({tag, "_incPC"}, incPC, 1'b0);
        chk({tag, "_loadFromI"}, loadFromI, 1'b0);
        chk({tag, "_I"}, I, 16'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_no_pc_ctl(tag);
        chk({tag, "_imem_req"}, imem_req, 1'b0);
        chk({tag, "_issue_valid"}, issue_valid, 1'b0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_halted"}, halted, 1'b0);
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [AW-1:0] tgt);
        logic [11:0] mid;
        mid = 12'($urandom);
        return {op, mid, tgt};
    endfunction

    function automatic logic [IW-1:0] mk_plain();
        return mk(4'($urandom_range(0, 12)), 16'($urandom));
    endfunction

    // Called in an IDLE or HALT cycle; returns in the first FETCH cycle.
    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clear_pc_reset", pc_reset, 1'b1);
        chk("clear_busy", busy, 1'b1);
        chk("clear_req", imem_req, 1'b0);
        chk("clear_halted", halted, 1'b0);
        step();
        exp_addr = '0;
    endtask

    // Runs one instruction starting in its FETCH cycle. ack_d/rdy_d are the
    // extra cycles before imem_ack/issue_ready; d[i] is the WAIT cycle in
    // which lane i reports. Returns in the cycle after UPDATE.
    task automatic run_instr(input logic [IW-1:0] w, input int ack_d, input int rdy_d,
                             input int d0, input int d1, input int d2, input int d3,
                             input logic cond, input bit spur);
        int         dl [4];
        int         maxd;
        logic [3:0] op;
        bit         ld;
        bit         hlt;
        dl[0] = d0; dl[1] = d1; dl[2] = d2; dl[3] = d3;
        maxd = 0;
        for (int i = 0; i < 4; i++) if (dl[i] > maxd) maxd = dl[i];
        op  = w[IW-1 -: 4];
        hlt = (op == 4'hF);
        ld  = (op == 4'hD) || ((op == 4'hE) && cond);
        branch_cond = cond;

        chk("fetch_addr", pc_model, exp_addr);
        for (int j = 0; j <= ack_d; j++) begin
            chk("fetch_req", imem_req, 1'b1);
            chk("fetch_valid", issue_valid, 1'b0);
            chk_no_pc_ctl("fetch");
            imem_ack  = (j == ack_d);
            imem_data = (j == ack_d) ? w : $urandom;
            core_done = spur ? 4'($urandom) : 4'h0;
            start     = 1'($urandom);
            step();
        end
        imem_ack  = 1'b0;
        imem_data = $urandom;

        for (int j = 0; j <= rdy_d; j++) begin
            chk("issue_valid", issue_valid, 1'b1);
            chk("issue_instr", instr, w);
            chk("issue_req", imem_req, 1'b0);
            chk_no_pc_ctl("issue");
            issue_ready = (j == rdy_d);
            core_done   = spur ? 4'hF : 4'h0;
            start       = 1'($urandom);
            step();
        end
        issue_ready = 1'b0;
        start       = 1'b0;

        for (int j = 0; j <= maxd; j++) begin
            chk("wait_valid", issue_valid, 1'b0);
            chk("wait_halted", halted, 1'b0);
            chk("wait_busy", busy, 1'b1);
            chk_no_pc_ctl("wait");
            for (int i = 0; i < 4; i++) core_done[i] = (dl[i] == j);
            step();
        end
        core_done = '0;

        chk("upd_incPC", incPC, !ld && !hlt);
        chk("upd_loadFromI", loadFromI, ld);
        chk("upd_I", I, ld ? w[AW-1:0] : 16'h0);
        chk("upd_pc_reset", pc_reset, 1'b0);
        chk("upd_busy", busy, 1'b1);
        chk("upd_req", imem_req, 1'b0);
        if (ld)        exp_addr = w[AW-1:0];
        else if (!hlt) exp_addr = exp_addr + 16'd1;
        step();

        if (hlt) begin
            chk("halt_halted", halted, 1'b1);
            chk("halt_busy", busy, 1'b0);
            chk("halt_req", imem_req, 1'b0);
        end else begin
            chk("next_req", imem_req, 1'b1);
        end
    endtask

    logic [IW-1:0] prog [4];

    initial begin
        // Reset state
        step();
        chk_all_zero("reset");
        reset_n = 1'b1;
        step();
        chk_all_zero("idle");

        // Launch with immediate acks: three plain instructions then HALT,
        // cycle numbers counted from the start cycle.
        for (int k = 0; k < 3; k++) prog[k] = mk_plain();
        prog[3] = mk(4'hF, 16'h0);
        imem_ack    = 1'b1;
        issue_ready = 1'b1;
        core_done   = '1;
        for (int c = 0; c <= 18; c++) begin
            chk("t1_pc_reset", pc_reset, c == 1);
            chk("t1_incPC", incPC, (c == 5) || (c == 9) || (c == 13));
            chk("t1_loadFromI", loadFromI, 1'b0);
            chk("t1_halted", halted, c == 18);
            chk("t1_imem_req", imem_req, (c >= 2) && (c <= 14) && ((c - 2) % 4 == 0));
            if (c == 18) break;
            start     = (c == 0);
            imem_data = prog[(c >= 2) ? (((c - 2) / 4 > 3) ? 3 : (c - 2) / 4) : 0];
            step();
        end
        imem_ack    = 1'b0;
        issue_ready = 1'b0;
        core_done   = '0;
        start       = 1'b0;

        // JMP, BRZ not taken, BRZ taken, relaunched from HALT
        launch();
        run_instr(mk(4'hD, 16'h0040), 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run_instr(mk(4'hE, 16'h1234), 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run_instr(mk(4'hE, 16'h0010), 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        run_instr(mk_plain(), 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        run_instr(mk(4'hF, 16'h0), 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // Staggered lanes with spurious completions before WAIT
        launch();
        run_instr(mk_plain(), 0, 0, 0, 2, 2, 5, 1'b0, 1'b1);
        run_instr(mk(4'hF, 16'h0), 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // Backpressure on both handshakes
        launch();
        run_instr(mk_plain(), 3, 2, 1, 0, 2, 1, 1'b0, 1'b0);
        run_instr(mk(4'hE, 16'h0123), 3, 2, 0, 0, 0, 0, 1'b1, 1'b0);
        run_instr(mk(4'hF, 16'h0), 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // Reset mid-WAIT with lanes 0..2 already reported
        launch();
        imem_ack  = 1'b1;
        imem_data = mk_plain();
        step();
        imem_ack    = 1'b0;
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        core_done   = 4'b0111;
        step();
        core_done = 4'b0000;
        #3;
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        step();
        reset_n = 1'b1;
        step();
        chk_all_zero("post_reset");
        launch();
        // Lane 3 reports first; the stale bits for lanes 0..2 must not count.
        run_instr(mk_plain(), 0, 0, 4, 4, 4, 0, 1'b0, 1'b0);
        run_instr(mk(4'hF, 16'h0), 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // Randomized program
        launch();
        for (int n = 0; n < 24; n++) begin
            run_instr(mk(4'($urandom_range(0, 14)), 16'($urandom)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      1'($urandom), 1'($urandom));
        end
        run_instr(mk(4'hF, 16'h0), 1, 1, 2, 0, 1, 0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
